// File: rtl/memory_arbiter.sv
// Sequential arbiter sharing one single-ported RAM between instruction fetch and data access.
// Data has priority; a saturating starvation counter forces a fetch after STARVE_MAX data grants.
module memory_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic [1:0]  gnt
);

    typedef enum logic [2:0] {
        IDLE,
        IACC,
        DACC,
        IRESP,
        DRESP
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [1:0] GNT_NONE   = 2'b00;
    localparam logic [1:0] GNT_INSTR  = 2'b01;
    localparam logic [1:0] GNT_DATA   = 2'b10;

    state_t      state_q;
    logic [3:0]  starve_q, starve_d;
    logic        ramREN_q, ramWEN_q;
    logic [31:0] ramaddr_q, ramstore_q;
    logic [31:0] iload_q, dload_q;
    logic        ihit_q, dhit_q;
    logic [1:0]  gnt_q;

    logic        d_req;
    logic        i_forced;
    logic        dgrant;
    logic        igrant;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
    endfunction

    always_comb begin
        d_req    = dREN | dWEN;
        i_forced = iREN && (starve_q == STARVE_LIM);
        dgrant   = (state_q == IDLE) && d_req && !i_forced;
        igrant   = (state_q == IDLE) && !dgrant && iREN;
        starve_d = starve_q;
        // The counter only moves on IDLE decisions; a stalled fetch counts data grants it lost.
        if (state_q == IDLE) begin
            if (igrant || !iREN) begin
                starve_d = 4'd0;
            end else if (dgrant) begin
                starve_d = sat_inc(starve_q);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            ramREN_q   <= 1'b0;
            ramWEN_q   <= 1'b0;
            ramaddr_q  <= 32'd0;
            ramstore_q <= 32'd0;
            iload_q    <= 32'd0;
            dload_q    <= 32'd0;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            gnt_q      <= GNT_NONE;
        end else begin
            starve_q <= starve_d;
            ihit_q   <= 1'b0;
            dhit_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dgrant) begin
                        // Write wins when both dREN and dWEN are raised.
                        state_q    <= DACC;
                        ramaddr_q  <= daddr;
                        ramstore_q <= dstore;
                        ramWEN_q   <= dWEN;
                        ramREN_q   <= ~dWEN;
                        gnt_q      <= GNT_DATA;
                    end else if (igrant) begin
                        state_q   <= IACC;
                        ramaddr_q <= iaddr;
                        ramWEN_q  <= 1'b0;
                        ramREN_q  <= 1'b1;
                        gnt_q     <= GNT_INSTR;
                    end else begin
                        gnt_q <= GNT_NONE;
                    end
                end
                IACC: begin
                    if (ramready) begin
                        state_q  <= IRESP;
                        iload_q  <= ramload;
                        ramREN_q <= 1'b0;
                        ihit_q   <= iREN;
                    end
                end
                DACC: begin
                    if (ramready) begin
                        state_q <= DRESP;
                        if (!ramWEN_q) begin
                            dload_q <= ramload;
                        end
                        ramREN_q <= 1'b0;
                        ramWEN_q <= 1'b0;
                        dhit_q   <= d_req;
                    end
                end
                IRESP, DRESP: begin
                    state_q <= IDLE;
                    gnt_q   <= GNT_NONE;
                end
                default: begin
                    state_q  <= IDLE;
                    ramREN_q <= 1'b0;
                    ramWEN_q <= 1'b0;
                    gnt_q    <= GNT_NONE;
                end
            endcase
        end
    end

    assign iload    = iload_q;
    assign ihit     = ihit_q;
    assign dload    = dload_q;
    assign dhit     = dhit_q;
    assign ramREN   = ramREN_q;
    assign ramWEN   = ramWEN_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign gnt      = gnt_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small word RAM model and hand-computed expectations.
module tb_memory_arbiter;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        ihit;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dhit;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;
    logic [1:0]  gnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];

    memory_arbiter #(.STARVE_MAX(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready),
        .gnt(gnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM model: combinational read, write committed on the ready edge.
    assign ramload = mem[ramaddr[9:0]];
    always @(posedge CLK) begin
        if (ramWEN && ramready) mem[ramaddr[9:0]] <= ramstore;
    end

    always @(posedge CLK) begin
        if (dREN && dWEN) $display("NOTE illegal stimulus: dREN and dWEN both asserted at %0t", $time);
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic dwrite(input logic [31:0] a, input logic [31:0] d);
        dWEN = 1'b1; daddr = a; dstore = d; ramready = 1'b1;
        tick(); tick();
        dWEN = 1'b0;
        tick();
    endtask

    logic [1:0] exp_gnt [6] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
    logic [3:0] exp_stv [6] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};

    initial begin
        RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramready = 1'b0;
        tick(); tick();
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_hits", {30'd0, ihit, dhit}, 32'd0);
        chk("rst_starve", 32'(dut.starve_q), 32'd0);
        RST = 1'b0;
        tick();

        // Write then read back
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramready = 1'b1;
        tick();
        chk("wr_ramWEN", 32'(ramWEN), 32'd1);
        chk("wr_ramREN", 32'(ramREN), 32'd0);
        chk("wr_ramaddr", ramaddr, 32'h100);
        chk("wr_ramstore", ramstore, 32'hDEADBEEF);
        chk("wr_gnt", 32'(gnt), 32'd2);
        tick();
        chk("wr_dhit", 32'(dhit), 32'd1);
        chk("wr_dload_hold", dload, 32'd0);
        chk("wr_ramWEN_off", 32'(ramWEN), 32'd0);
        dWEN = 1'b0;
        tick();
        chk("wr_dhit_pulse", 32'(dhit), 32'd0);
        dREN = 1'b1;
        tick();
        chk("rd_ramREN", 32'(ramREN), 32'd1);
        tick();
        chk("rd_dhit", 32'(dhit), 32'd1);
        chk("rd_dload", dload, 32'hDEADBEEF);
        dREN = 1'b0;
        tick();

        // Single fetch
        dwrite(32'h40, 32'h8C220004);
        iREN = 1'b1; iaddr = 32'h40;
        tick();
        chk("if_ramaddr", ramaddr, 32'h40);
        chk("if_ramREN", 32'(ramREN), 32'd1);
        chk("if_gnt", 32'(gnt), 32'd1);
        chk("if_ihit_c1", 32'(ihit), 32'd0);
        tick();
        chk("if_ihit_c2", 32'(ihit), 32'd1);
        chk("if_iload", iload, 32'h8C220004);
        iREN = 1'b0;
        tick();
        chk("if_ihit_c3", 32'(ihit), 32'd0);
        chk("if_gnt_idle", 32'(gnt), 32'd0);

        // Contention: data first, fetch at the next IDLE
        iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h100;
        tick();
        chk("ct_gnt_c1", 32'(gnt), 32'd2);
        tick();
        chk("ct_dhit_c2", 32'(dhit), 32'd1);
        chk("ct_ihit_c2", 32'(ihit), 32'd0);
        dREN = 1'b0;
        tick();
        chk("ct_starve_c3", 32'(dut.starve_q), 32'd1);
        chk("ct_gnt_c3", 32'(gnt), 32'd0);
        tick();
        chk("ct_gnt_c4", 32'(gnt), 32'd1);
        chk("ct_starve_c4", 32'(dut.starve_q), 32'd0);
        tick();
        chk("ct_ihit_c5", 32'(ihit), 32'd1);
        iREN = 1'b0;
        tick();

        // Starvation with STARVE_MAX=2
        iREN = 1'b1; dREN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("sv_gnt%0d", i), 32'(gnt), 32'(exp_gnt[i]));
            chk($sformatf("sv_starve%0d", i), 32'(dut.starve_q), 32'(exp_stv[i]));
            tick(); tick();
        end
        iREN = 1'b0; dREN = 1'b0;
        tick();

        // Withdrawn fetch with three wait cycles
        ramready = 1'b0; iREN = 1'b1; iaddr = 32'h100;
        tick();
        chk("wd_ramREN_c1", 32'(ramREN), 32'd1);
        iREN = 1'b0;
        tick(); tick();
        chk("wd_ramREN_c3", 32'(ramREN), 32'd1);
        chk("wd_gnt_c3", 32'(gnt), 32'd1);
        tick();
        ramready = 1'b1;
        tick();
        chk("wd_ihit", 32'(ihit), 32'd0);
        chk("wd_iload", iload, 32'hDEADBEEF);
        chk("wd_ramREN_off", 32'(ramREN), 32'd0);
        tick();
        chk("wd_gnt_idle", 32'(gnt), 32'd0);

        // Both dREN and dWEN: write wins
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678;
        tick();
        chk("bo_ramWEN", 32'(ramWEN), 32'd1);
        chk("bo_ramREN", 32'(ramREN), 32'd0);
        tick();
        chk("bo_dhit", 32'(dhit), 32'd1);
        chk("bo_dload", dload, 32'hDEADBEEF);
        dREN = 1'b0; dWEN = 1'b0;
        tick();

        // Reset in the middle of a data write
        ramready = 1'b0; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hCAFEF00D;
        tick();
        chk("mr_ramWEN_pre", 32'(ramWEN), 32'd1);
        RST = 1'b1;
        tick();
        chk("mr_ramWEN", 32'(ramWEN), 32'd0);
        chk("mr_gnt", 32'(gnt), 32'd0);
        chk("mr_dhit", 32'(dhit), 32'd0);
        chk("mr_ramaddr", ramaddr, 32'd0);
        chk("mr_ramstore", ramstore, 32'd0);
        chk("mr_iload", iload, 32'd0);
        chk("mr_dload", dload, 32'd0);
        chk("mr_starve", 32'(dut.starve_q), 32'd0);
        dWEN = 1'b0;
        RST = 1'b0;
        tick();
        chk("mr_idle_gnt", 32'(gnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
